// File: rtl/inst_queue_pkg.sv
// Shared instruction-queue types and the default depth constant.
// Imported by the queue, and by anything that wants to reuse the entry layout.
package inst_queue_pkg;

    localparam int IQ_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch/decode-facing bundle of the instruction queue.
// slave = the queue itself, master = the fetch/decode environment.
interface inst_queue_if;

    logic [1:0][31:0] pc;
    logic [1:0][31:0] instr;
    logic             is_branch_established;
    logic [1:0]       can_proceed;
    logic [1:0]       deq_ready;
    logic [1:0]       out_valid;
    logic [1:0][31:0] out_pc;
    logic [1:0][31:0] out_instr;

    modport slave (
        input  pc,
        input  instr,
        input  is_branch_established,
        input  deq_ready,
        output can_proceed,
        output out_valid,
        output out_pc,
        output out_instr
    );

    modport master (
        output pc,
        output instr,
        output is_branch_established,
        output deq_ready,
        input  can_proceed,
        input  out_valid,
        input  out_pc,
        input  out_instr
    );

endinterface

// File: rtl/inst_queue.sv
// Two-wide circular instruction queue between fetch and decode.
// Optional macro INST_QUEUE_STALL_CNT_EN adds the stall_cycles counter output.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
`ifdef INST_QUEUE_STALL_CNT_EN
    output logic [31:0] stall_cycles,
`endif
    inst_queue_if.slave q
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] ROOM_ONE = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ROOM_TWO = CW'(DEPTH - 2);
    localparam logic [CW-1:0] CNT_TWO  = CW'(2);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    iq_entry_t     mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          flush;
    logic          acc0, acc1;
    logic          ov0, ov1;
    logic          enq0, enq1;
    logic          deq0, deq1;
    logic [1:0]    enq_n, deq_n;
    iq_entry_t     rd0, rd1;

    // Acceptance and validity come only from registered count (no deq_ready path).
    always_comb begin
        flush = q.is_branch_established;
        acc0  = (count_q <= ROOM_ONE);
        acc1  = (count_q <= ROOM_TWO);
        ov0   = (count_q != '0) && !flush;
        ov1   = (count_q >= CNT_TWO) && !flush;
        enq0  = acc0 && !flush;
        enq1  = acc1 && !flush;
        deq0  = ov0 && q.deq_ready[0];
        deq1  = deq0 && ov1 && q.deq_ready[1];
        enq_n = {1'b0, enq0} + {1'b0, enq1};
        deq_n = {1'b0, deq0} + {1'b0, deq1};
    end

    // Pointer and occupancy next state; a redirect empties the queue outright.
    always_comb begin
        head_d  = head_q + PW'(deq_n);
        tail_d  = tail_q + PW'(enq_n);
        count_d = count_q + CW'(enq_n) - CW'(deq_n);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; slot 1 lands one past slot 0, wrapping with the pointer width.
    always_ff @(posedge clk) begin
        if (enq0) begin
            mem_q[tail_q] <= '{pc: q.pc[0], instr: q.instr[0]};
        end
        if (enq1) begin
            mem_q[tail_q + PTR_ONE] <= '{pc: q.pc[1], instr: q.instr[1]};
        end
    end

    // Oldest two entries are presented straight from storage.
    always_comb begin
        rd0 = mem_q[head_q];
        rd1 = mem_q[head_q + PTR_ONE];
    end

    assign q.can_proceed  = {acc1, acc0};
    assign q.out_valid    = {ov1, ov0};
    assign q.out_pc[0]    = rd0.pc;
    assign q.out_pc[1]    = rd1.pc;
    assign q.out_instr[0] = rd0.instr;
    assign q.out_instr[1] = rd1.instr;

`ifdef INST_QUEUE_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Count full-queue cycles that are not being flushed, saturating at max.
    always_comb begin
        stall_d = stall_q;
        if (!acc0 && !flush && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_inst_queue;

    localparam int D = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    inst_queue_if iq ();

`ifdef INST_QUEUE_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    inst_queue #(.DEPTH(D)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef INST_QUEUE_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .q            (iq)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] mq [$];
    logic [31:0] exp_stall = '0;

    typedef struct {
        logic [31:0] pc0;
        logic        br;
        logic [1:0]  dr;
        logic [1:0]  cp;
        logic [1:0]  ov;
        logic [31:0] o0;
        logic [31:0] o1;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, check against the model,
    // then advance the model across the rising edge.
    task automatic step(input logic [31:0] pc0, input logic br,
                        input logic [1:0] dr,
                        output logic [1:0] s_cp, output logic [1:0] s_ov,
                        output logic [31:0] s_o0, output logic [31:0] s_o1);
        int n;
        int take;
        logic e0, e1;
        logic [31:0] i0, i1, p1;
        i0 = $urandom;
        i1 = $urandom;
        p1 = pc0 + 32'd4;
        iq.pc[0] = pc0;
        iq.pc[1] = p1;
        iq.instr[0] = i0;
        iq.instr[1] = i1;
        iq.is_branch_established = br;
        iq.deq_ready = dr;
        #1;
        n = mq.size();
        e0 = (n <= D - 1);
        e1 = (n <= D - 2);
        s_cp = iq.can_proceed;
        s_ov = iq.out_valid;
        s_o0 = iq.out_pc[0];
        s_o1 = iq.out_pc[1];
        chk("can_proceed", {62'd0, iq.can_proceed}, {62'd0, e1, e0});
        chk("out_valid", {62'd0, iq.out_valid},
            {62'd0, (!br && n >= 2), (!br && n >= 1)});
        if (!br && n >= 1)
            chk("slot0", {iq.out_pc[0], iq.out_instr[0]}, mq[0]);
        if (!br && n >= 2)
            chk("slot1", {iq.out_pc[1], iq.out_instr[1]}, mq[1]);
`ifdef INST_QUEUE_STALL_CNT_EN
        chk("stall_cycles", {32'd0, stall_cycles}, {32'd0, exp_stall});
`endif
        @(posedge clk);
        if (br) begin
            mq.delete();
        end else begin
            take = 0;
            if (n >= 1 && dr[0]) take = (n >= 2 && dr[1]) ? 2 : 1;
            repeat (take) void'(mq.pop_front());
            if (e0) mq.push_back({pc0, i0});
            if (e1) mq.push_back({p1, i1});
            if (!e0 && exp_stall != '1) exp_stall++;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_can_proceed"}, {62'd0, iq.can_proceed}, 64'd3);
        chk({tag, "_out_valid"}, {62'd0, iq.out_valid}, 64'd0);
`ifdef INST_QUEUE_STALL_CNT_EN
        chk({tag, "_stall"}, {32'd0, stall_cycles}, 64'd0);
`endif
    endtask

    initial begin
        logic [1:0]  cp, ov;
        logic [31:0] o0, o1;
        logic [31:0] pcr;

        tbl[0]  = '{32'h00, 1'b0, 2'b00, 2'b11, 2'b00, 32'h0,  32'h0};
        tbl[1]  = '{32'h00, 1'b0, 2'b00, 2'b11, 2'b11, 32'h0,  32'h4};
        tbl[2]  = '{32'h00, 1'b0, 2'b00, 2'b11, 2'b11, 32'h0,  32'h4};
        tbl[3]  = '{32'h00, 1'b0, 2'b00, 2'b11, 2'b11, 32'h0,  32'h4};
        tbl[4]  = '{32'h00, 1'b0, 2'b00, 2'b00, 2'b11, 32'h0,  32'h4};
        tbl[5]  = '{32'h00, 1'b0, 2'b11, 2'b00, 2'b11, 32'h0,  32'h4};
        tbl[6]  = '{32'h40, 1'b0, 2'b01, 2'b11, 2'b11, 32'h0,  32'h4};
        tbl[7]  = '{32'h50, 1'b0, 2'b00, 2'b01, 2'b11, 32'h4,  32'h0};
        tbl[8]  = '{32'h58, 1'b0, 2'b10, 2'b00, 2'b11, 32'h4,  32'h0};
        tbl[9]  = '{32'h58, 1'b0, 2'b11, 2'b00, 2'b11, 32'h4,  32'h0};
        tbl[10] = '{32'h60, 1'b0, 2'b11, 2'b11, 2'b11, 32'h4,  32'h0};
        tbl[11] = '{32'h70, 1'b0, 2'b01, 2'b11, 2'b11, 32'h4,  32'h40};
        tbl[12] = '{32'h80, 1'b1, 2'b11, 2'b01, 2'b00, 32'h0,  32'h0};
        tbl[13] = '{32'h90, 1'b0, 2'b00, 2'b11, 2'b00, 32'h0,  32'h0};
        tbl[14] = '{32'hA0, 1'b0, 2'b11, 2'b11, 2'b11, 32'h90, 32'h94};
        tbl[15] = '{32'hB0, 1'b1, 2'b00, 2'b11, 2'b00, 32'h0,  32'h0};
        tbl[16] = '{32'hC0, 1'b0, 2'b00, 2'b11, 2'b00, 32'h0,  32'h0};

        iq.pc = '0;
        iq.instr = '0;
        iq.is_branch_established = 1'b0;
        iq.deq_ready = 2'b00;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;

        // Directed table: fill, full, partial accept, dequeue, flush.
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].pc0, tbl[i].br, tbl[i].dr, cp, ov, o0, o1);
            chk($sformatf("tbl%0d_cp", i), {62'd0, cp}, {62'd0, tbl[i].cp});
            chk($sformatf("tbl%0d_ov", i), {62'd0, ov}, {62'd0, tbl[i].ov});
            if (tbl[i].ov[0])
                chk($sformatf("tbl%0d_pc0", i), {32'd0, o0}, {32'd0, tbl[i].o0});
            if (tbl[i].ov[1])
                chk($sformatf("tbl%0d_pc1", i), {32'd0, o1}, {32'd0, tbl[i].o1});
        end

        // Asynchronous reset with four entries queued.
        step(32'hD0, 1'b0, 2'b00, cp, ov, o0, o1);
        chk("pre_reset_count", {32'd0, mq.size()}, 64'd4);
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        mq.delete();
        exp_stall = '0;

        // Steer tail to DEPTH-1, then enqueue a pair across the wrap.
        for (int i = 0; i < 4; i++)
            step(32'h10 * (i + 1), 1'b0, 2'b00, cp, ov, o0, o1);
        step(32'h50, 1'b0, 2'b11, cp, ov, o0, o1);
        step(32'h60, 1'b0, 2'b01, cp, ov, o0, o1);
        step(32'h70, 1'b0, 2'b11, cp, ov, o0, o1);
        step(32'h80, 1'b0, 2'b11, cp, ov, o0, o1);
        step(32'h90, 1'b0, 2'b11, cp, ov, o0, o1);
        step(32'h100, 1'b0, 2'b00, cp, ov, o0, o1);
        chk("wrap_cp_before", {62'd0, cp}, 64'd3);
        for (int i = 0; i < 6; i++)
            step(32'h200 + 32'h10 * i, 1'b0, 2'b01, cp, ov, o0, o1);
        step(32'h300, 1'b0, 2'b01, cp, ov, o0, o1);
        chk("wrap_head_pc0", {32'd0, o0}, 64'h100);
        chk("wrap_head_pc1", {32'd0, o1}, 64'h104);
        step(32'h310, 1'b0, 2'b00, cp, ov, o0, o1);
        chk("wrap_next_pc0", {32'd0, o0}, 64'h104);

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            pcr = $urandom & 32'hFFFF_FFF8;
            step(pcr, ($urandom_range(0, 15) == 0),
                 2'($urandom_range(0, 3)), cp, ov, o0, o1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 8, queue entries; power of two, >= 4.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: pc  input  32 x2  addresses of fetch slot 0 and slot 1 this cycle (pc[1] = pc[0]+4).
REQ-005 SHALL have port: instr  input  32 x2  instruction words matching pc[0], pc[1].
REQ-006 SHALL have port: is_branch_established  input  1  redirect; flush all queued and incoming instructions.
REQ-007 SHALL have port: can_proceed  output  1 x2  slot i accepted into queue this cycle; returned to fetch.
REQ-008 SHALL have port: deq_ready  input  1 x2  decode accepts output slot i this cycle.
REQ-009 SHALL have port: out_valid  output  1 x2  output slot i holds a valid instruction.
REQ-010 SHALL have port: out_pc, out_instr  output  32 x2  pc/word of the oldest (slot 0) and second-oldest (slot 1) entries.

Function
REQ-011 SHALL be a circular FIFO with head, tail pointers (log2(DEPTH) bits, wrap modulo DEPTH) and count (log2(DEPTH)+1 bits).
REQ-012 can_proceed[0] SHALL be 1 iff registered count <= DEPTH-1; can_proceed[1] iff count <= DEPTH-2; same-cycle dequeue never raises acceptance (no combinational path from deq_ready).
REQ-013 can_proceed[1]=1 SHALL imply can_proceed[0]=1; slots enqueue strictly in order.
REQ-014 Enqueue count SHALL be can_proceed[0]+can_proceed[1] when is_branch_established=0, else 0.
REQ-015 out_valid[0] SHALL be (count>=1) and out_valid[1] (count>=2), both forced 0 while is_branch_established=1.
REQ-016 Effective dequeue count SHALL be 0, 1 (out_valid[0]&deq_ready[0]), or 2 (additionally out_valid[1]&deq_ready[1]); deq_ready[1] without deq_ready[0] SHALL dequeue nothing.
REQ-017 Simultaneous enqueue and dequeue SHALL update count by enq-deq in one cycle; data written at tail, read at head, one-cycle latency enqueue-to-out_valid.
REQ-018 Flush SHALL set head=tail=0, count=0 next cycle, discarding stored entries and the incoming pair; flush dominates enqueue and dequeue.
REQ-019 Pointer wrap SHALL be exact: a two-entry enqueue at tail=DEPTH-1 writes entries DEPTH-1 and 0.
REQ-020 Count SHALL never exceed DEPTH nor underflow.

Reset
REQ-021 Asserting reset SHALL immediately clear head, tail, count; can_proceed={1,1}, out_valid={0,0}; entry storage need not reset.
REQ-022 Reset asserted mid-operation SHALL discard all entries; first enqueue allowed in the first clock edge after release.

Configuration
REQ-023 Macro INST_QUEUE_STALL_CNT_EN defined: SHALL add output stall_cycles (32 bits) counting cycles with can_proceed[0]=0 and is_branch_established=0, saturating at 2^32-1, cleared by reset.
REQ-024 Macro undefined: port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-025 Shared core package SHALL hold IQ_DEPTH default constant and typedef iq_entry_t {pc[31:0], instr[31:0]}.
REQ-026 Storage, pointers, count SHALL live in this module; no sub-module required.

Verification
REQ-027 Reset, then pc={0x0,0x4}, no deq for 4 cycles -> count=8, can_proceed={0,0} on cycle 5, out_pc={0x0,0x4}.
REQ-028 Count=7, deq_ready={0,0}, enqueue -> can_proceed={1,0}; only pc[0] stored, count=8.
REQ-029 Count=8, deq_ready={1,1} -> out_pc={0x0,0x4} consumed, count=6, can_proceed still {0,0} that cycle, {1,1} next.
REQ-030 Count=5, is_branch_established=1 with deq_ready={1,1} -> out_valid={0,0} that cycle, count=0 next, no enqueue.
REQ-031 Tail=7, count=2, enqueue pc={0x100,0x104} -> entries at 7 and 0; sequential dequeue yields 0x100 then 0x104.
REQ-032 Reset pulsed low mid-stream with count=4 -> outputs return to reset values asynchronously; with INST_QUEUE_STALL_CNT_EN, stall_cycles=0.
